// File: rtl/odo_pkg.sv
// Shared types and default sizes for the odometer ring-oscillator readouts.
package odo_pkg;

    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned WIN_W_DEF       = 16;
    localparam int unsigned SETTLE_CYC_DEF  = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rosc_edge_counter_if.sv
// Measurement request/result bundle between the readout logic and the edge counter.
interface rosc_edge_counter_if
    import odo_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned WIN_W = WIN_W_DEF
);
    logic             ROSC_IN;
    logic             START;
    logic [WIN_W-1:0] WINDOW;
    logic             ROSC_EN;
    logic             BUSY;
    logic             DONE;
    logic [CNT_W-1:0] COUNT;
    logic             OVF;

    modport slave (
        input  ROSC_IN, START, WINDOW,
        output ROSC_EN, BUSY, DONE, COUNT, OVF
    );

    modport master (
        output ROSC_IN, START, WINDOW,
        input  ROSC_EN, BUSY, DONE, COUNT, OVF
    );
endinterface

// File: rtl/rosc_sync_edge.sv
// Multi-flop synchronizer for an asynchronous oscillator output plus rising-edge detect.
module rosc_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic ASYNC_IN,
    output logic RISE
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ASYNC_IN};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Decoded straight from flops, so no input reaches RISE combinationally.
    assign RISE = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/rosc_edge_counter.sv
// Gates a ring oscillator, waits a settle interval, then counts its rising edges
// over a programmed window of clock cycles and strobes DONE with the result.
module rosc_edge_counter
    import odo_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned WIN_W       = WIN_W_DEF,
    parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    rosc_edge_counter_if.slave  bus
);
    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TMR_W = max_u(WIN_W, SET_W);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_e             state_q, state_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               rosc_en_q, rosc_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rise;

    rosc_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .CLK      (CLK),
        .RST      (RST),
        .ASYNC_IN (bus.ROSC_IN),
        .RISE     (rise)
    );

    // One timer serves both the settle interval and the measurement window.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        tmr_d   = tmr_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    state_d = ST_SETTLE;
                    win_d   = bus.WINDOW;
                    tmr_d   = SETTLE_LOAD;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (tmr_q == '0) begin
                    if (win_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_MEASURE;
                        tmr_d   = TMR_W'(win_q - WIN_W'(1));
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    if (count_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                if (tmr_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are decoded from the next state so they can be registered.
        rosc_en_d = (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
        busy_d    = rosc_en_d;
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            win_q     <= '0;
            tmr_q     <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            rosc_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            tmr_q     <= tmr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            rosc_en_q <= rosc_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.ROSC_EN = rosc_en_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.COUNT   = count_q;
    assign bus.OVF     = ovf_q;

endmodule

// File: tb/tb_rosc_edge_counter.sv
// Scoreboard bench: two counters (16-bit and 4-bit COUNT) run the same directed stimulus.
module tb_rosc_edge_counter;

    localparam int unsigned SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] window = '0;
    logic        rosc_in = 1'b0;
    int          rosc_per = 0;
    int          ph = 0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_fail = 0;

    typedef struct {
        logic [15:0] count;
        logic        ovf;
        int          done_cyc;
        int          en_cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   en_a = 0;
    int   en_b = 0;

    rosc_edge_counter_if #(.CNT_W(16), .WIN_W(16)) bus_a ();
    rosc_edge_counter_if #(.CNT_W(4),  .WIN_W(16)) bus_b ();

    assign bus_a.ROSC_IN = rosc_in;
    assign bus_a.START   = start;
    assign bus_a.WINDOW  = window;
    assign bus_b.ROSC_IN = rosc_in;
    assign bus_b.START   = start;
    assign bus_b.WINDOW  = window;

    rosc_edge_counter #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(SETTLE), .SYNC_STAGES(2))
        dut_a (.CLK(clk), .RST(rst), .bus(bus_a));
    rosc_edge_counter #(.CNT_W(4), .WIN_W(16), .SETTLE_CYC(SETTLE), .SYNC_STAGES(2))
        dut_b (.CLK(clk), .RST(rst), .bus(bus_b));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Free-running oscillator model, clock-aligned; period 0 holds the current level.
    always @(negedge clk) begin
        if (rosc_per != 0) begin
            ph      = (ph + 1) % rosc_per;
            rosc_in = (ph < rosc_per / 2);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_done(input string tag, input bit have, input exp_t e,
                              input logic [15:0] cnt, input logic ovf, input int en);
        if (!have) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s unexpected DONE: got strobe at cycle %0d, expected none", tag, cyc);
        end else begin
            chk({tag, " count"},    32'(cnt),  32'(e.count));
            chk({tag, " ovf"},      32'(ovf),  32'(e.ovf));
            chk({tag, " done_cyc"}, cyc,       e.done_cyc);
            chk({tag, " en_cyc"},   en,        e.en_cyc);
        end
    endtask

    // Monitor: every DONE strobe is matched against the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        if (rst) begin
            en_a = 0;
            en_b = 0;
        end else begin
            if (bus_a.ROSC_EN) en_a++;
            if (bus_b.ROSC_EN) en_b++;
            if (bus_a.DONE) begin
                have = (q_a.size() != 0);
                if (have) e = q_a.pop_front();
                check_done("a", have, e, bus_a.COUNT, bus_a.OVF, en_a);
                en_a = 0;
            end
            if (bus_b.DONE) begin
                have = (q_b.size() != 0);
                if (have) e = q_b.pop_front();
                check_done("b", have, e, 16'(bus_b.COUNT), bus_b.OVF, en_b);
                en_b = 0;
            end
        end
    end

    task automatic start_run(input int w, input int cnt_a, input bit ovf_a,
                             input int cnt_b, input bit ovf_b);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        window = 16'(w);
        e.done_cyc = cyc + int'(SETTLE) + w + 1;
        e.en_cyc   = int'(SETTLE) + w;
        e.count = 16'(cnt_a); e.ovf = ovf_a; q_a.push_back(e);
        e.count = 16'(cnt_b); e.ovf = ovf_b; q_b.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL done timeout: %0d/%0d results pending after %0d cycles, expected 0",
                     q_a.size(), q_b.size(), budget);
            q_a.delete();
            q_b.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset rosc_en", 32'(bus_a.ROSC_EN), 0);
        chk("reset busy",    32'(bus_a.BUSY),    0);
        chk("reset done",    32'(bus_a.DONE),    0);
        chk("reset count",   32'(bus_a.COUNT),   0);
        chk("reset ovf",     32'(bus_a.OVF),     0);
        chk("reset b count", 32'(bus_b.COUNT),   0);
        @(negedge clk);
        rst = 1'b0;

        // Period 10 over 100 cycles: 10 edges.
        rosc_per = 10;
        repeat (20) @(negedge clk);
        start_run(100, 10, 1'b0, 10, 1'b0);
        wait_done(400);

        // Period 4 over 100 cycles: 25 edges, 4-bit counter saturates.
        rosc_per = 4;
        repeat (20) @(negedge clk);
        start_run(100, 25, 1'b0, 15, 1'b1);
        wait_done(400);

        // Zero window: settle only, nothing counted.
        start_run(0, 0, 1'b0, 0, 1'b0);
        wait_done(50);

        // START retriggered in MEASURE and in the DONE cycle is ignored.
        rosc_per = 10;
        repeat (20) @(negedge clk);
        start_run(30, 3, 1'b0, 3, 1'b0);
        repeat (15) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && !bus_a.DONE; i++) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("retrig busy a",  32'(bus_a.BUSY),  0);
        chk("retrig busy b",  32'(bus_b.BUSY),  0);
        chk("retrig count a", 32'(bus_a.COUNT), 3);
        chk("retrig count b", 32'(bus_b.COUNT), 3);
        wait_done(10);

        // Asynchronous reset in the middle of MEASURE aborts without DONE.
        start_run(100, 10, 1'b0, 10, 1'b0);
        repeat (40) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort rosc_en", 32'(bus_a.ROSC_EN), 0);
        chk("abort busy",    32'(bus_a.BUSY),    0);
        chk("abort count",   32'(bus_a.COUNT),   0);
        chk("abort ovf",     32'(bus_a.OVF),     0);
        chk("abort done",    32'(bus_a.DONE),    0);
        q_a.delete();
        q_b.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        start_run(100, 10, 1'b0, 10, 1'b0);
        wait_done(400);

        // Static oscillator; WINDOW rewritten mid-run must not alter the run length.
        rosc_per = 0;
        repeat (20) @(negedge clk);
        start_run(50, 0, 1'b0, 0, 1'b0);
        repeat (10) @(negedge clk);
        window = 16'd7;
        wait_done(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
